pattern_detect_ctrl: RTL

Controller for a programmable serial pattern detector.
- Holds the pattern/mask configuration and arms and disarms the match core.
- Counts hits and enforces a timeout window.
- Reports one termination event per run over a valid/ready handshake.
- Sits between the register/config bus and the serial bit stream; replaces fixed-pattern detectors with a run-time programmable one.

---
 rtl/pdc_pkg.sv | 23 ++
 rtl/pattern_detect_ctrl_core.sv | 56 +++++
 rtl/pattern_detect_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pdc_pkg.sv
// pdc_pkg: shared definitions for the programmable pattern detector.
//   pdc_state_e : controller state encoding (binary, 2 bits)
//   EVT_*       : termination codes reported on evt_code
//   pdc_is_busy : true for the states in which the match core runs
package pdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_HUNT   = 2'd2,
    ST_REPORT = 2'd3
  } pdc_state_e;

  localparam logic [1:0] EVT_NONE  = 2'b00;
  localparam logic [1:0] EVT_DONE  = 2'b01;
  localparam logic [1:0] EVT_TMO   = 2'b10;
  localparam logic [1:0] EVT_ABORT = 2'b11;

  function automatic logic pdc_is_busy(input pdc_state_e s);
    return (s == ST_FILL) || (s == ST_HUNT);
  endfunction

endpackage

// File: rtl/pattern_detect_ctrl_core.sv
// pattern_match_core: serial shift register, fill counter and masked compare.
// Ports:
//   clk, rstn          clock, async active-low reset
//   clr                clear shift history and fill count (start of a run)
//   en                 shift d in this cycle (d_vld while busy)
//   d                  serial data bit
//   pattern, mask      compare value and care-mask (MSB = oldest bit)
//   full_next          history holds PAT_W bits after this cycle's shift
//   match              combinational: this cycle's shift completes a match
module pattern_match_core
  import pdc_pkg::*;
#(
  parameter int PAT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic             d,
  input  logic [PAT_W-1:0] pattern,
  input  logic [PAT_W-1:0] mask,
  output logic             full_next,
  output logic             match
);

  localparam int FC_W = $clog2(PAT_W + 1);

  // Only the newest PAT_W-1 bits are stored: the oldest bit of the window
  // is shifted out on the very next shift, so it never needs to be kept.
  // The compare window is these bits plus the incoming d.
  logic [PAT_W-2:0] hist;
  logic [PAT_W-1:0] shreg_next;
  logic [FC_W-1:0]  fill_cnt;

  assign shreg_next = {hist, d};

  // Full either already, or the current shift brings in the PAT_W-th bit.
  assign full_next = (fill_cnt == FC_W'(PAT_W)) ||
                     (en && (fill_cnt == FC_W'(PAT_W - 1)));

  assign match = en && full_next && (((shreg_next ^ pattern) & mask) == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist     <= '0;
      fill_cnt <= '0;
    end else if (clr) begin
      hist     <= '0;
      fill_cnt <= '0;
    end else if (en) begin
      hist <= shreg_next[PAT_W-2:0];
      if (fill_cnt != FC_W'(PAT_W)) fill_cnt <= fill_cnt + FC_W'(1);
    end
  end

endmodule

// File: rtl/pattern_detect_ctrl.sv
// pattern_detect_ctrl: controller for a run-time programmable serial
// pattern detector. Latches pattern/mask config in IDLE, runs the match
// core through FILL and HUNT, counts hits, enforces a timeout and reports
// one termination event per run on a valid/ready handshake.
// Ports:
//   clk, rstn                 clock, async active-low reset
//   cfg_wr + cfg_*            config write (IDLE only)
//   start, abort              begin run (IDLE) / cancel run (FILL, HUNT)
//   d, d_vld                  serial data stream
//   busy, hit_pulse           run active / one-cycle pulse per match
//   evt_valid/ready/code/hits termination event
//   first_hit_idx             timer value of first match (only when the
//                             PDC_FIRST_HIT_IDX_EN macro is defined)
//   dbg_state                 current controller state
// Event handshake: evt_valid rises on entry to REPORT with evt_code and
// evt_hits registered alongside; all three hold until a cycle with
// evt_valid && evt_ready, after which the controller is back in IDLE and
// evt_valid is low.
module pattern_detect_ctrl
  import pdc_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cfg_wr,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic [TMO_W-1:0] cfg_timeout,
  input  logic [CNT_W-1:0] cfg_max_hits,
  input  logic             start,
  input  logic             abort,
  input  logic             d,
  input  logic             d_vld,
  output logic             busy,
  output logic             hit_pulse,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_code,
  output logic [CNT_W-1:0] evt_hits,
`ifdef PDC_FIRST_HIT_IDX_EN
  output logic [TMO_W-1:0] first_hit_idx,
`endif
  output pdc_state_e       dbg_state
);

  pdc_state_e       state;
  logic [PAT_W-1:0] pattern_r;
  logic [PAT_W-1:0] mask_r;
  logic [TMO_W-1:0] timeout_r;
  logic [CNT_W-1:0] max_hits_r;
  logic [TMO_W-1:0] timer;
  logic [CNT_W-1:0] hits;
  logic [CNT_W-1:0] hits_next;
  logic             core_clr;
  logic             core_en;
  logic             full_next;
  logic             match;
  logic             done_fire;
  logic             tmo_fire;

  assign busy      = pdc_is_busy(state);
  assign dbg_state = state;
  assign core_en   = d_vld & busy;
  assign core_clr  = (state == ST_IDLE) && start;

  pattern_match_core #(.PAT_W(PAT_W)) u_core (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (core_clr),
    .en        (core_en),
    .d         (d),
    .pattern   (pattern_r),
    .mask      (mask_r),
    .full_next (full_next),
    .match     (match)
  );

  // Saturating hit count including this cycle's match.
  always_comb begin
    hits_next = hits;
    if (match && (hits != '1)) hits_next = hits + CNT_W'(1);
  end

  assign done_fire = match && (max_hits_r != '0) && (hits_next == max_hits_r);
  assign tmo_fire  = (timeout_r != '0) && ((timer + TMO_W'(1)) == timeout_r);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      pattern_r     <= '0;
      mask_r        <= '0;
      timeout_r     <= '0;
      max_hits_r    <= '0;
      timer         <= '0;
      hits          <= '0;
      hit_pulse     <= 1'b0;
      evt_valid     <= 1'b0;
      evt_code      <= EVT_NONE;
      evt_hits      <= '0;
`ifdef PDC_FIRST_HIT_IDX_EN
      first_hit_idx <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          hit_pulse <= 1'b0;
          if (cfg_wr) begin
            pattern_r  <= cfg_pattern;
            mask_r     <= cfg_mask;
            timeout_r  <= cfg_timeout;
            max_hits_r <= cfg_max_hits;
          end
          if (start) begin
            state <= ST_FILL;
            timer <= '0;
            hits  <= '0;
`ifdef PDC_FIRST_HIT_IDX_EN
            first_hit_idx <= '0;
`endif
          end
        end

        ST_FILL, ST_HUNT: begin
          hit_pulse <= match;
          hits      <= hits_next;
          timer     <= timer + TMO_W'(1);
`ifdef PDC_FIRST_HIT_IDX_EN
          // hits only returns to zero on start, so zero means no hit yet.
          if (match && (hits == '0)) first_hit_idx <= timer;
`endif
          if ((state == ST_FILL) && core_en && full_next) state <= ST_HUNT;

          // Termination overrides the FILL->HUNT step above.
          if (abort || done_fire || tmo_fire) begin
            state     <= ST_REPORT;
            evt_valid <= 1'b1;
            evt_hits  <= hits_next;
            if (abort)          evt_code <= EVT_ABORT;
            else if (done_fire) evt_code <= EVT_DONE;
            else                evt_code <= EVT_TMO;
          end
        end

        ST_REPORT: begin
          hit_pulse <= 1'b0;
          if (evt_ready) begin
            state     <= ST_IDLE;
            evt_valid <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
